// File: rtl/vjtag_readback.sv
// vjtag_readback: fabric-to-host return path of the Virtual JTAG link.
// One-entry buffer in clk, drained by the host through a shift DR on tck.
// Optional `VJTAG_RB_SEQ_EN: 8-bit accept sequence number stored with each
// word and shifted out as the DR MSBs.
module vjtag_readback #(
  parameter int unsigned DATA_W  = 32,
  parameter logic [2:0]  IR_READ = 3'b010
) (
  input  logic              clk,
  input  logic              aclr,
  input  logic              tck,
  input  logic              tdi,
  input  logic [2:0]        ir_in,
  input  logic              v_cdr,
  input  logic              v_sdr,
  input  logic              v_udr,
  output logic              tdo,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              overflow
);

`ifdef VJTAG_RB_SEQ_EN
  localparam int unsigned SEQ_W = 8;
  localparam int unsigned DR_W  = DATA_W + 2 + SEQ_W;
`else
  localparam int unsigned DR_W  = DATA_W + 2;
`endif

  // clk domain state
  logic [DATA_W-1:0] hold_data;
  logic              full;
  logic              req_tgl;
  logic              ack_s1, ack_s2, ack_d;
  logic              ack_edge;
`ifdef VJTAG_RB_SEQ_EN
  logic [SEQ_W-1:0]  seq;
  logic [SEQ_W-1:0]  hold_seq;
`endif

  // tck domain state
  logic              req_s1, req_s2;
  logic              ovf_s1, ovf_s2;
  logic              ack_tgl;
  logic              cap_valid;
  logic              bypass_reg;
  logic [DR_W-1:0]   dr;
  logic [DR_W-1:0]   cap_word;
  logic              avail;
  logic              ir_sel;

  assign ack_edge  = ack_s2 ^ ack_d;
  assign din_ready = ~full;
  assign avail     = req_s2 ^ ack_tgl;
  assign ir_sel    = (ir_in == IR_READ);
  assign tdo       = ir_sel ? dr[0] : bypass_reg;

  // Fabric side: accept into the hold buffer, flag drops, release on host ack
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      hold_data <= '0;
      full      <= 1'b0;
      req_tgl   <= 1'b0;
      overflow  <= 1'b0;
      ack_s1    <= 1'b0;
      ack_s2    <= 1'b0;
      ack_d     <= 1'b0;
`ifdef VJTAG_RB_SEQ_EN
      seq       <= '0;
      hold_seq  <= '0;
`endif
    end else begin
      ack_s1 <= ack_tgl;
      ack_s2 <= ack_s1;
      ack_d  <= ack_s2;
      if (ack_edge) begin
        // Release only happens while full, so it never collides with an accept
        full     <= 1'b0;
        overflow <= 1'b0;
      end else if (din_valid) begin
        if (full) begin
          overflow <= 1'b1;
        end else begin
          hold_data <= din;
          full      <= 1'b1;
          req_tgl   <= ~req_tgl;
`ifdef VJTAG_RB_SEQ_EN
          hold_seq  <= seq;
          seq       <= SEQ_W'(seq + 1'b1);
`endif
        end
      end
    end
  end

  // Capture image: flags in the LSBs, payload (and seq) only when a word is pending
  always_comb begin
    cap_word    = '0;
    cap_word[1] = ovf_s2;
    if (avail) begin
      cap_word[0]            = 1'b1;
      cap_word[DATA_W+1:2]   = hold_data;
`ifdef VJTAG_RB_SEQ_EN
      cap_word[DR_W-1 -: SEQ_W] = hold_seq;
`endif
    end
  end

  // Host side: synchronizers, capture/shift/update of the readback DR, bypass
  always_ff @(posedge tck or posedge aclr) begin
    if (aclr) begin
      req_s1     <= 1'b0;
      req_s2     <= 1'b0;
      ovf_s1     <= 1'b0;
      ovf_s2     <= 1'b0;
      ack_tgl    <= 1'b0;
      cap_valid  <= 1'b0;
      bypass_reg <= 1'b0;
      dr         <= '0;
    end else begin
      req_s1     <= req_tgl;
      req_s2     <= req_s1;
      ovf_s1     <= overflow;
      ovf_s2     <= ovf_s1;
      bypass_reg <= tdi;
      if (ir_sel) begin
        if (v_cdr) begin
          // hold_data is stable while avail can be 1, so it is sampled directly
          dr        <= cap_word;
          cap_valid <= avail;
        end else if (v_sdr) begin
          dr <= {tdi, dr[DR_W-1:1]};
        end else if (v_udr && cap_valid) begin
          // One ack per capture; repeated updates are ignored
          ack_tgl   <= ~ack_tgl;
          cap_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_vjtag_readback.sv
// Directed bench for vjtag_readback (default build and VJTAG_RB_SEQ_EN build).
module tb_vjtag_readback;

  localparam int unsigned DATA_W  = 32;
  localparam logic [2:0]  IR_READ = 3'b010;
`ifdef VJTAG_RB_SEQ_EN
  localparam int unsigned DR_W = DATA_W + 10;
`else
  localparam int unsigned DR_W = DATA_W + 2;
`endif

  logic              clk = 1'b0;
  logic              tck = 1'b0;
  logic              aclr;
  logic              tdi;
  logic [2:0]        ir_in;
  logic              v_cdr, v_sdr, v_udr;
  logic              tdo;
  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              din_ready;
  logic              overflow;

  int total = 0;
  int bad   = 0;
  logic [7:0]  tb_seq;
  logic [63:0] rd;

  vjtag_readback #(.DATA_W(DATA_W), .IR_READ(IR_READ)) dut (
    .clk(clk), .aclr(aclr), .tck(tck), .tdi(tdi), .ir_in(ir_in),
    .v_cdr(v_cdr), .v_sdr(v_sdr), .v_udr(v_udr), .tdo(tdo),
    .din(din), .din_valid(din_valid), .din_ready(din_ready), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always #7 tck = ~tck;

  // Compare and count one observation
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] exp_dr(input logic [7:0] s, input logic [31:0] d,
                                         input logic o, input logic a);
`ifdef VJTAG_RB_SEQ_EN
    return {22'b0, s, d, o, a};
`else
    return {30'b0, d, o, a} | {56'b0, s & 8'h00};
`endif
  endfunction

  task automatic push(input logic [31:0] w, input logic accepted);
    @(negedge clk);
    din       = w;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    if (accepted) tb_seq = 8'(tb_seq + 8'd1);
  endtask

  // Optionally capture, then shift the whole DR out, collecting tdo LSB first
  task automatic read_dr(input logic do_cap, output logic [63:0] v);
    v     = '0;
    ir_in = IR_READ;
    tdi   = 1'b0;
    if (do_cap) begin
      @(negedge tck);
      v_cdr = 1'b1;
    end
    @(negedge tck);
    v_cdr = 1'b0;
    v_sdr = 1'b1;
    for (int i = 0; i < int'(DR_W); i++) begin
      v[i] = tdo;
      @(negedge tck);
    end
    v_sdr = 1'b0;
  endtask

  task automatic update();
    @(negedge tck);
    v_udr = 1'b1;
    @(negedge tck);
    v_udr = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!din_ready && n < 5) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(din_ready), 64'd1);
  endtask

  task automatic settle_tck();
    repeat (4) @(negedge tck);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] pat;
    aclr = 1'b1; tdi = 1'b0; ir_in = IR_READ;
    v_cdr = 1'b0; v_sdr = 1'b0; v_udr = 1'b0;
    din = '0; din_valid = 1'b0; tb_seq = 8'd0;
    #33 aclr = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state and empty read
    check("rst_ready", 64'(din_ready), 64'd1);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_tdo", 64'(tdo), 64'd0);
    read_dr(1'b1, rd);
    check("rst_dr", rd, 64'd0);
    check("rst_ready2", 64'(din_ready), 64'd1);

    // Single word round trip
    push(32'hDEADBEEF, 1'b1);
    check("acc_ready", 64'(din_ready), 64'd0);
    settle_tck();
    read_dr(1'b1, rd);
    check("word1_dr", rd, exp_dr(8'd0, 32'hDEADBEEF, 1'b0, 1'b1));
    check("word1_flags", rd[1:0], 64'd1);
    repeat (4) @(negedge clk);
    check("hold_ready", 64'(din_ready), 64'd0);
    update();
    wait_ready("word1_release");

    // Overflow: second offer while full is dropped
    push(32'hDEADBEEF, 1'b1);
    push(32'h12345678, 1'b0);
    check("ovf_set", 64'(overflow), 64'd1);
    check("ovf_ready", 64'(din_ready), 64'd0);
    settle_tck();
    read_dr(1'b1, rd);
    check("ovf_dr", rd, exp_dr(8'd1, 32'hDEADBEEF, 1'b1, 1'b1));
    update();
    wait_ready("ovf_release");
    check("ovf_clr", 64'(overflow), 64'd0);

    // Double update after one capture acks once
    push(32'h55AA00FF, 1'b1);
    settle_tck();
    read_dr(1'b1, rd);
    check("dbl_dr", rd, exp_dr(8'd2, 32'h55AA00FF, 1'b0, 1'b1));
    update();
    update();
    wait_ready("dbl_release");
    settle_tck();
    read_dr(1'b1, rd);
    check("dbl_empty", rd, 64'd0);
    push(32'h00000001, 1'b1);
    settle_tck();
    read_dr(1'b1, rd);
    check("next_dr", rd, exp_dr(8'd3, 32'h00000001, 1'b0, 1'b1));
    update();
    wait_ready("next_release");

    // Bypass with another IR: tdo is tdi delayed one tck, DR and ack untouched
    push(32'hCAFEF00D, 1'b1);
    settle_tck();
    @(negedge tck);
    v_cdr = 1'b1;
    @(negedge tck);
    v_cdr = 1'b0;
    check("cap_lsb", 64'(tdo), 64'd1);
    ir_in = 3'b001;
    pat   = 8'b1011_0010;
    v_sdr = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tdi = pat[i];
      @(negedge tck);
      check($sformatf("byp%0d", i), 64'(tdo), 64'(pat[i]));
    end
    v_sdr = 1'b0;
    tdi   = 1'b0;
    update();
    ir_in = IR_READ;
    #1;
    check("dr_kept", 64'(tdo), 64'd1);
    repeat (6) @(negedge clk);
    check("no_ack", 64'(din_ready), 64'd0);
    read_dr(1'b0, rd);
    check("byp_dr", rd, exp_dr(8'd4, 32'hCAFEF00D, 1'b0, 1'b1));
    update();
    wait_ready("byp_release");

    // Reset during a shift discards the pending word
    push(32'h0BADF00D, 1'b1);
    settle_tck();
    @(negedge tck);
    v_cdr = 1'b1;
    @(negedge tck);
    v_cdr = 1'b0;
    v_sdr = 1'b1;
    repeat (5) @(negedge tck);
    #3 aclr = 1'b1;
    #9 aclr = 1'b0;
    v_sdr  = 1'b0;
    tb_seq = 8'd0;
    repeat (2) @(negedge clk);
    check("aclr_ready", 64'(din_ready), 64'd1);
    check("aclr_ovf", 64'(overflow), 64'd0);
    check("aclr_tdo", 64'(tdo), 64'd0);
    read_dr(1'b1, rd);
    check("aclr_dr", rd, 64'd0);
    push(32'h00000077, 1'b1);
    settle_tck();
    read_dr(1'b1, rd);
    check("aclr_seq0", rd, exp_dr(8'd0, 32'h00000077, 1'b0, 1'b1));
    update();
    wait_ready("aclr_release");

`ifdef VJTAG_RB_SEQ_EN
    // Sequence field runs 0..255 and wraps to 0
    @(negedge clk);
    aclr = 1'b1;
    #4 aclr = 1'b0;
    tb_seq = 8'd0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 257; i++) begin
      push(32'(i * 3 + 5), 1'b1);
      settle_tck();
      read_dr(1'b1, rd);
      check($sformatf("seq%0d", i), rd, exp_dr(8'(i), 32'(i * 3 + 5), 1'b0, 1'b1));
      update();
      wait_ready($sformatf("seq_rel%0d", i));
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
